trigger_deadlock_recovery_ctrl: RTL and testbench

- Supervisory controller for the trigger core.
- Consumes the registered block flag from the deadlock monitor and the raw per-AXIS block vector.
- Declares a deadlock after a programmable run of consecutive blocked cycles, then sequences a soft reset of the core.
- Verifies the core drains cleanly, retries a bounded number of times, then latches a fault for software.

---
 rtl/trigger_deadlock_recovery_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_trigger_deadlock_recovery_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_deadlock_recovery_ctrl.sv
// Supervisory deadlock detector for the trigger core. It declares a deadlock after a
// programmable run of blocked cycles, pulses the core soft reset, checks the drain, and latches a fault.
module trigger_deadlock_recovery_ctrl #(
  parameter int AXIS_N        = 7,
  parameter int CNT_W         = 16,
  parameter int EVT_W         = 8,
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 32,
  parameter int MAX_RETRY     = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [CNT_W-1:0]  threshold,
  input  logic              clear,
  input  logic              block_in,
  input  logic [AXIS_N-1:0] axis_block_sigs,
  output logic              core_soft_rst_n,
  output logic              irq,
  output logic              fault,
  output logic [2:0]        state,
  output logic [EVT_W-1:0]  deadlock_events,
  output logic [AXIS_N-1:0] block_mask
);

  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int STL_W = $clog2(SETTLE_CYCLES + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_SUSPECT = 3'd2,
    S_RECOVER = 3'd3,
    S_DRAIN   = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  state_t             r_state,       w_state_nxt;
  logic [CNT_W-1:0]   r_stall_cnt,   w_stall_cnt_nxt;
  logic [RST_W-1:0]   r_rst_cnt,     w_rst_cnt_nxt;
  logic [STL_W-1:0]   r_settle_cnt,  w_settle_cnt_nxt;
  logic [RTY_W-1:0]   r_retry_cnt,   w_retry_cnt_nxt;
  logic               r_dis_pend,    w_dis_pend_nxt;
  logic               r_core_rst_n,  w_core_rst_n_nxt;
  logic               r_irq,         w_irq_nxt;
  logic               r_fault,       w_fault_nxt;
  logic [EVT_W-1:0]   r_events,      w_events_nxt;
  logic [AXIS_N-1:0]  r_mask,        w_mask_nxt;

  logic               w_declare;
  logic [CNT_W-1:0]   w_thr_eff;
  logic [CNT_W:0]     w_stall_inc;

  // A zero threshold behaves like one; the extra bit keeps the compare safe at full scale.
  assign w_thr_eff   = (threshold == '0) ? CNT_W'(1) : threshold;
  assign w_stall_inc = {1'b0, r_stall_cnt} + (CNT_W+1)'(1);

  always_comb begin
    // NOTE: every next-state value is defaulted to its current value first, so no path
    // through the case statement can leave a signal unassigned and infer a latch.
    w_state_nxt      = r_state;
    w_stall_cnt_nxt  = r_stall_cnt;
    w_rst_cnt_nxt    = r_rst_cnt;
    w_settle_cnt_nxt = r_settle_cnt;
    w_retry_cnt_nxt  = r_retry_cnt;
    w_dis_pend_nxt   = r_dis_pend;
    w_core_rst_n_nxt = r_core_rst_n;
    w_irq_nxt        = r_irq;
    w_fault_nxt      = r_fault;
    w_events_nxt     = r_events;
    w_mask_nxt       = r_mask;
    w_declare        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (enable) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (!enable) begin
          w_state_nxt = S_IDLE;
        end else if (block_in) begin
          if (w_thr_eff == CNT_W'(1)) begin
            w_declare = 1'b1;
          end else begin
            w_state_nxt     = S_SUSPECT;
            w_stall_cnt_nxt = CNT_W'(1);
          end
        end
      end
      S_SUSPECT: begin
        if (!enable) begin
          w_state_nxt     = S_IDLE;
          w_stall_cnt_nxt = '0;
        end else if (!block_in) begin
          w_state_nxt     = S_ARMED;
          w_stall_cnt_nxt = '0;
        end else if (w_stall_inc >= {1'b0, w_thr_eff}) begin
          w_declare = 1'b1;
        end else begin
          w_stall_cnt_nxt = w_stall_inc[CNT_W-1:0];
        end
      end
      S_RECOVER: begin
        if (r_rst_cnt == RST_W'(RST_CYCLES - 1)) begin
          w_state_nxt      = S_DRAIN;
          w_rst_cnt_nxt    = '0;
          w_core_rst_n_nxt = 1'b1;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + RST_W'(1);
        end
      end
      S_DRAIN: begin
        if (!enable) w_dis_pend_nxt = 1'b1;
        if (block_in) begin
          w_settle_cnt_nxt = '0;
          w_core_rst_n_nxt = 1'b0;
          if (r_retry_cnt == RTY_W'(MAX_RETRY)) begin
            w_state_nxt    = S_FAULT;
            w_fault_nxt    = 1'b1;
            w_dis_pend_nxt = 1'b0;
          end else begin
            w_state_nxt     = S_RECOVER;
            w_retry_cnt_nxt = r_retry_cnt + RTY_W'(1);
            w_rst_cnt_nxt   = '0;
          end
        end else if (r_settle_cnt == STL_W'(SETTLE_CYCLES - 1)) begin
          // A disable seen at any point during the drain takes effect only once it settles.
          w_state_nxt      = (r_dis_pend || !enable) ? S_IDLE : S_ARMED;
          w_settle_cnt_nxt = '0;
          w_retry_cnt_nxt  = '0;
          w_dis_pend_nxt   = 1'b0;
        end else begin
          w_settle_cnt_nxt = r_settle_cnt + STL_W'(1);
        end
      end
      S_FAULT: begin
        w_core_rst_n_nxt = 1'b0;
        w_fault_nxt      = 1'b1;
        if (clear) begin
          w_state_nxt      = S_IDLE;
          w_core_rst_n_nxt = 1'b1;
          w_fault_nxt      = 1'b0;
          w_stall_cnt_nxt  = '0;
          w_rst_cnt_nxt    = '0;
          w_settle_cnt_nxt = '0;
          w_retry_cnt_nxt  = '0;
          w_dis_pend_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // A declaration on the same edge as clear wins and restarts the event count at one.
    if (w_declare) begin
      w_state_nxt      = S_RECOVER;
      w_mask_nxt       = axis_block_sigs;
      w_stall_cnt_nxt  = '0;
      w_rst_cnt_nxt    = '0;
      w_retry_cnt_nxt  = r_retry_cnt + RTY_W'(1);
      w_core_rst_n_nxt = 1'b0;
      w_irq_nxt        = 1'b1;
      if (clear)                w_events_nxt = EVT_W'(1);
      else if (r_events != '1)  w_events_nxt = r_events + EVT_W'(1);
    end else if (clear) begin
      w_irq_nxt    = 1'b0;
      w_events_nxt = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_stall_cnt  <= '0;
      r_rst_cnt    <= '0;
      r_settle_cnt <= '0;
      r_retry_cnt  <= '0;
      r_dis_pend   <= 1'b0;
      r_core_rst_n <= 1'b1;
      r_irq        <= 1'b0;
      r_fault      <= 1'b0;
      r_events     <= '0;
      r_mask       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_stall_cnt  <= w_stall_cnt_nxt;
      r_rst_cnt    <= w_rst_cnt_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      r_retry_cnt  <= w_retry_cnt_nxt;
      r_dis_pend   <= w_dis_pend_nxt;
      r_core_rst_n <= w_core_rst_n_nxt;
      r_irq        <= w_irq_nxt;
      r_fault      <= w_fault_nxt;
      r_events     <= w_events_nxt;
      r_mask       <= w_mask_nxt;
    end
  end

  assign core_soft_rst_n = r_core_rst_n;
  assign irq             = r_irq;
  assign fault           = r_fault;
  assign state           = r_state;
  assign deadlock_events = r_events;
  assign block_mask      = r_mask;

endmodule

// File: tb/tb_trigger_deadlock_recovery_ctrl.sv
// Directed bench for trigger_deadlock_recovery_ctrl: a vector table for the threshold
// boundary, then hand sequences for reset pulse, retry/fault, clear race, async reset, saturation.
module tb_trigger_deadlock_recovery_ctrl;

  localparam int AXIS_N = 7;
  localparam int CNT_W  = 16;
  localparam int EVT_W  = 8;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              enable;
  logic [CNT_W-1:0]  threshold;
  logic              clear;
  logic              block_in;
  logic [AXIS_N-1:0] axis_block_sigs;
  logic              core_soft_rst_n;
  logic              irq;
  logic              fault;
  logic [2:0]        state;
  logic [EVT_W-1:0]  deadlock_events;
  logic [AXIS_N-1:0] block_mask;

  int total = 0;
  int bad   = 0;

  trigger_deadlock_recovery_ctrl dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .enable          (enable),
    .threshold       (threshold),
    .clear           (clear),
    .block_in        (block_in),
    .axis_block_sigs (axis_block_sigs),
    .core_soft_rst_n (core_soft_rst_n),
    .irq             (irq),
    .fault           (fault),
    .state           (state),
    .deadlock_events (deadlock_events),
    .block_mask      (block_mask)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic              en;
    logic [CNT_W-1:0]  thr;
    logic              clr;
    logic              blk;
    logic [AXIS_N-1:0] axis;
    logic [2:0]        st;
    logic              rst_n;
    logic              irq;
    logic [EVT_W-1:0]  ev;
    logic [AXIS_N-1:0] mask;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Needs ARMED with threshold <= 1: one high sample declares, then the drain is allowed to settle.
  task automatic decl_recover();
    block_in = 1'b1;
    step();
    block_in = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (state == 3'd1) break;
      step();
    end
    check("recover_done", 32'(state), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_cnt;
    int pulses;
    int cur_len;
    int bad_len;
    logic prev_rst_n;

    vecs[0] = '{1'b1, 16'd4, 1'b0, 1'b0, 7'h7f, 3'd1, 1'b1, 1'b0, 8'd0, 7'h00};
    vecs[1] = '{1'b1, 16'd4, 1'b0, 1'b1, 7'h7f, 3'd2, 1'b1, 1'b0, 8'd0, 7'h00};
    vecs[2] = '{1'b1, 16'd4, 1'b0, 1'b1, 7'h7f, 3'd2, 1'b1, 1'b0, 8'd0, 7'h00};
    vecs[3] = '{1'b1, 16'd4, 1'b0, 1'b1, 7'h7f, 3'd2, 1'b1, 1'b0, 8'd0, 7'h00};
    vecs[4] = '{1'b1, 16'd4, 1'b0, 1'b0, 7'h7f, 3'd1, 1'b1, 1'b0, 8'd0, 7'h00};
    vecs[5] = '{1'b1, 16'd4, 1'b0, 1'b1, 7'h7f, 3'd2, 1'b1, 1'b0, 8'd0, 7'h00};
    vecs[6] = '{1'b1, 16'd4, 1'b0, 1'b1, 7'h7f, 3'd2, 1'b1, 1'b0, 8'd0, 7'h00};
    vecs[7] = '{1'b1, 16'd4, 1'b0, 1'b1, 7'h7f, 3'd2, 1'b1, 1'b0, 8'd0, 7'h00};
    vecs[8] = '{1'b1, 16'd4, 1'b0, 1'b1, 7'h14, 3'd3, 1'b0, 1'b1, 8'd1, 7'h14};

    reset_n         = 1'b0;
    enable          = 1'b0;
    threshold       = 16'd4;
    clear           = 1'b0;
    block_in        = 1'b0;
    axis_block_sigs = '0;
    #12;
    check("reset_state", 32'(state), 32'd0);
    check("reset_rst_n", 32'(core_soft_rst_n), 32'd1);
    check("reset_irq",   32'(irq), 32'd0);
    check("reset_fault", 32'(fault), 32'd0);
    check("reset_events", 32'(deadlock_events), 32'd0);
    check("reset_mask",  32'(block_mask), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    step();

    // Threshold boundary: three highs fall back, four highs declare.
    for (int i = 0; i < 9; i++) begin
      enable          = vecs[i].en;
      threshold       = vecs[i].thr;
      clear           = vecs[i].clr;
      block_in        = vecs[i].blk;
      axis_block_sigs = vecs[i].axis;
      step();
      check($sformatf("vec%0d_state", i),  32'(state), 32'(vecs[i].st));
      check($sformatf("vec%0d_rst_n", i),  32'(core_soft_rst_n), 32'(vecs[i].rst_n));
      check($sformatf("vec%0d_irq", i),    32'(irq), 32'(vecs[i].irq));
      check($sformatf("vec%0d_events", i), 32'(deadlock_events), 32'(vecs[i].ev));
      check($sformatf("vec%0d_mask", i),   32'(block_mask), 32'(vecs[i].mask));
    end

    // Soft-reset pulse width, then a clean settle back to ARMED.
    block_in = 1'b0;
    low_cnt  = 1;
    for (int i = 0; i < 100; i++) begin
      if (core_soft_rst_n !== 1'b0) break;
      step();
      if (core_soft_rst_n === 1'b0) low_cnt++;
    end
    check("pulse_width", 32'(low_cnt), 32'd16);
    check("pulse_then_drain", 32'(state), 32'd4);
    for (int i = 0; i < 31; i++) step();
    check("drain_31", 32'(state), 32'd4);
    step();
    check("drain_32_armed", 32'(state), 32'd1);

    // Retry to fault with block_in held high.
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_irq", 32'(irq), 32'd0);
    check("clear_events", 32'(deadlock_events), 32'd0);
    check("clear_mask_kept", 32'(block_mask), 32'h14);
    block_in   = 1'b1;
    pulses     = 0;
    cur_len    = 0;
    bad_len    = 0;
    prev_rst_n = core_soft_rst_n;
    for (int i = 0; i < 400; i++) begin
      step();
      if (core_soft_rst_n === 1'b0) cur_len++;
      if (prev_rst_n === 1'b0 && core_soft_rst_n === 1'b1) begin
        pulses++;
        if (cur_len != 16) bad_len++;
        cur_len = 0;
      end
      prev_rst_n = core_soft_rst_n;
      if (state == 3'd5) break;
    end
    check("retry_pulses", 32'(pulses), 32'd3);
    check("retry_pulse_len", 32'(bad_len), 32'd0);
    check("fault_state", 32'(state), 32'd5);
    check("fault_flag", 32'(fault), 32'd1);
    check("fault_rst_n", 32'(core_soft_rst_n), 32'd0);
    check("fault_events", 32'(deadlock_events), 32'd1);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("fault_sticky", 32'(state), 32'd5);
    enable = 1'b1;
    clear  = 1'b1;
    block_in = 1'b0;
    step();
    clear = 1'b0;
    check("fault_exit_state", 32'(state), 32'd0);
    check("fault_exit_flag", 32'(fault), 32'd0);
    check("fault_exit_irq", 32'(irq), 32'd0);
    check("fault_exit_rst_n", 32'(core_soft_rst_n), 32'd1);

    // Clear on the declaration edge: declaration wins.
    threshold = 16'd1;
    axis_block_sigs = 7'h21;
    step();
    check("idle_to_armed", 32'(state), 32'd1);
    for (int i = 0; i < 5; i++) decl_recover();
    check("events_five", 32'(deadlock_events), 32'd5);
    block_in = 1'b1;
    clear    = 1'b1;
    step();
    block_in = 1'b0;
    clear    = 1'b0;
    check("race_state", 32'(state), 32'd3);
    check("race_irq", 32'(irq), 32'd1);
    check("race_events", 32'(deadlock_events), 32'd1);

    // Asynchronous reset five cycles into the pulse, away from any clock edge.
    for (int i = 0; i < 5; i++) step();
    check("pre_async_state", 32'(state), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_state", 32'(state), 32'd0);
    check("async_rst_n", 32'(core_soft_rst_n), 32'd1);
    check("async_irq", 32'(irq), 32'd0);
    check("async_events", 32'(deadlock_events), 32'd0);
    check("async_mask", 32'(block_mask), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // threshold=0 declares on one sample; the event counter saturates.
    threshold       = 16'd0;
    axis_block_sigs = 7'h55;
    step();
    check("sat_armed", 32'(state), 32'd1);
    for (int i = 0; i < 300; i++) begin
      decl_recover();
      if (i == 254) check("events_at_255", 32'(deadlock_events), 32'd255);
    end
    check("events_saturated", 32'(deadlock_events), 32'd255);
    check("sat_mask", 32'(block_mask), 32'h55);

    // Disable during DRAIN is deferred until the drain settles.
    block_in = 1'b1;
    step();
    block_in = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (state == 3'd4) break;
      step();
    end
    check("defer_in_drain", 32'(state), 32'd4);
    enable = 1'b0;
    step();
    enable = 1'b1;
    check("defer_still_drain", 32'(state), 32'd4);
    for (int i = 0; i < 100; i++) begin
      if (state != 3'd4) break;
      step();
    end
    check("defer_to_idle", 32'(state), 32'd0);

    // Lowering threshold below the running stall count declares on the next high sample.
    threshold = 16'd10;
    step();
    check("thr_armed", 32'(state), 32'd1);
    block_in = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("thr_suspect", 32'(state), 32'd2);
    threshold = 16'd2;
    step();
    block_in = 1'b0;
    check("thr_lower_declares", 32'(state), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
